mem_arbiter: RTL and testbench

Shares the single 32-bit external SRAM between the RISC5 CPU data port and the video refresh port. It serialises accesses, generates the CPU's stallX, and drives SRAM address, data, write enable and byte enables. Video has priority, with a bounded starvation limit for the CPU. The I/O region bypasses the arbiter.

---
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared external SRAM arbiter between the CPU data port and video refresh.
// Video wins by default; a pending CPU request is let through after VBURST video grants.
module mem_arbiter #(
  parameter int AW     = 18,
  parameter int WAIT   = 1,
  parameter int VBURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic          cpu_ben,
  input  logic [23:0]   cpu_adr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          stallX,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_adr,
  output logic          vid_ack,
  output logic [31:0]   vid_data,
  output logic [AW-1:0] sram_adr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          sram_ce,
  output logic          sram_we,
  output logic [3:0]    sram_be
);
  localparam int CW = (WAIT > 0) ? $clog2(WAIT + 1) : 1;
  localparam int VW = $clog2(VBURST + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT);
  localparam logic [VW-1:0] VMAX     = VW'(VBURST);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_VID} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          done_q, done_d;
  logic          vid_ack_q, vid_ack_d;
  logic          ce_q, ce_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   vid_data_q, vid_data_d;
  logic          io, cpu_req, gnt_vid, gnt_cpu;
  logic [3:0]    cpu_be;

  assign io      = &cpu_adr[23:6];
  assign cpu_req = (cpu_rd | cpu_wr) & ~io;
  assign cpu_be  = cpu_ben ? (4'b0001 << cpu_adr[1:0]) : 4'b1111;
  // done is registered, so the CPU sees exactly one unstalled cycle per access
  assign stallX  = rst & cpu_req & ~done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vcnt_d      = vcnt_q;
    done_d      = 1'b0;
    vid_ack_d   = 1'b0;
    ce_d        = ce_q;
    we_d        = we_q;
    be_d        = be_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    vid_data_d  = vid_data_q;
    gnt_vid     = 1'b0;
    gnt_cpu     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (vid_req && !(cpu_req && vcnt_q == VMAX)) gnt_vid = 1'b1;
        else if (cpu_req && !done_q)                 gnt_cpu = 1'b1;
      end
      S_CPU, S_VID: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          if (state_q == S_CPU) begin
            cpu_rdata_d = sram_rdata;
            done_d      = 1'b1;
          end else begin
            vid_data_d = sram_rdata;
            vid_ack_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (gnt_vid) begin
      state_d = S_VID;
      cnt_d   = CNT_LOAD;
      ce_d    = 1'b1;
      we_d    = 1'b0;
      be_d    = 4'b1111;
      adr_d   = vid_adr;
      wdata_d = '0;
    end
    if (gnt_cpu) begin
      state_d = S_CPU;
      cnt_d   = CNT_LOAD;
      ce_d    = 1'b1;
      we_d    = cpu_wr;
      be_d    = cpu_be;
      adr_d   = cpu_adr[AW+1:2];
      wdata_d = cpu_wdata;
    end

    // video streak only matters while the CPU is actually waiting
    if (!cpu_req || gnt_cpu)             vcnt_d = '0;
    else if (gnt_vid && vcnt_q != VMAX)  vcnt_d = vcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vcnt_q      <= '0;
      done_q      <= 1'b0;
      vid_ack_q   <= 1'b0;
      ce_q        <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= '0;
      adr_q       <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vcnt_q      <= vcnt_d;
      done_q      <= done_d;
      vid_ack_q   <= vid_ack_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      be_q        <= be_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_data_q  <= vid_data_d;
    end
  end

  assign cpu_rdata  = cpu_rdata_q;
  assign vid_ack    = vid_ack_q;
  assign vid_data   = vid_data_q;
  assign sram_adr   = adr_q;
  assign sram_wdata = wdata_q;
  assign sram_ce    = ce_q;
  assign sram_we    = we_q;
  assign sram_be    = be_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, SRAM model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;
  localparam int AW = 18, WAIT = 1, VBURST = 4;

  logic          clk = 1'b0, rst = 1'b0;
  logic          cpu_rd = 1'b0, cpu_wr = 1'b0, cpu_ben = 1'b0;
  logic [23:0]   cpu_adr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic [31:0]   cpu_rdata;
  logic          stallX;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_adr = '0;
  logic          vid_ack;
  logic [31:0]   vid_data;
  logic [AW-1:0] sram_adr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata = '0;
  logic          sram_ce, sram_we;
  logic [3:0]    sram_be;

  mem_arbiter #(.AW(AW), .WAIT(WAIT), .VBURST(VBURST)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_ben(cpu_ben),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stallX(stallX),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_ack(vid_ack), .vid_data(vid_data),
    .sram_adr(sram_adr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be));

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // memories: env_mem is the SRAM seen by the DUT, mdl_mem is the model's own view
  logic [31:0] env_mem [int];
  logic [31:0] mdl_mem [int];

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3A50000;
  endfunction
  function automatic logic [31:0] env_rd(input int a);
    return env_mem.exists(a) ? env_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] mdl_rd(input int a);
    return mdl_mem.exists(a) ? mdl_mem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = wd[l*8 +: 8];
    return r;
  endfunction

  always @(negedge clk) begin : sram_model
    if (sram_ce && sram_we)
      env_mem[int'(sram_adr)] = merge(env_rd(int'(sram_adr)), sram_wdata, sram_be);
    sram_rdata <= env_rd(int'(sram_adr));
  end

  // reference model: owner 0=none 1=cpu 2=video, cycles left in the access
  bit            model_on = 1'b0;
  int            m_own = 0, m_left = 0, m_streak = 0;
  logic          m_done = 1'b0, m_vack = 1'b0, m_we = 1'b0, m_rdok = 1'b0;
  logic [AW-1:0] m_adr = '0;
  logic [3:0]    m_be = '0;
  logic [31:0]   m_wdata = '0, m_cdata = '0, m_vdata = '0;

  always @(negedge clk) begin : ref_model
    logic creq, gv, gc;
    if (model_on) begin
      creq = (cpu_rd || cpu_wr) && (cpu_adr[23:6] != 18'h3FFFF);
      chk("stallX",   32'(stallX),   32'(rst && creq && !m_done));
      chk("sram_ce",  32'(sram_ce),  32'(m_own != 0));
      chk("sram_we",  32'(sram_we),  32'(m_own == 1 && m_we));
      chk("sram_adr", 32'(sram_adr), 32'(m_adr));
      chk("sram_be",  32'(sram_be),  32'(m_be));
      chk("vid_ack",  32'(vid_ack),  32'(m_vack));
      if (m_vack)             chk("vid_data", vid_data, m_vdata);
      if (m_done && m_rdok)   chk("cpu_rdata", cpu_rdata, m_cdata);
      if (m_own == 1 && m_we) chk("sram_wdata", sram_wdata, m_wdata);

      if (!rst) begin
        m_own = 0; m_left = 0; m_streak = 0; m_done = 0; m_vack = 0; m_we = 0; m_rdok = 0;
        m_adr = '0; m_be = '0; m_wdata = '0; m_cdata = '0; m_vdata = '0;
      end else begin
        gv = 1'b0; gc = 1'b0;
        if (m_own != 0) begin
          m_done = 0; m_vack = 0;
          m_left--;
          if (m_left == 0) begin
            if (m_own == 1) begin m_done = 1; m_rdok = !m_we; m_cdata = mdl_rd(int'(m_adr)); end
            else begin m_vack = 1; m_vdata = mdl_rd(int'(m_adr)); end
            m_own = 0; m_we = 0;
          end
        end else begin
          gv = vid_req && !(creq && m_streak == VBURST);
          gc = !gv && creq && !m_done;
          m_done = 0; m_vack = 0;
          if (gv) begin
            m_own = 2; m_left = WAIT + 1; m_adr = vid_adr; m_be = 4'hF; m_we = 0;
          end else if (gc) begin
            m_own = 1; m_left = WAIT + 1; m_adr = cpu_adr[AW+1:2];
            m_be = cpu_ben ? (4'b0001 << cpu_adr[1:0]) : 4'hF;
            m_we = cpu_wr; m_wdata = cpu_wdata;
            if (cpu_wr) mdl_mem[int'(m_adr)] = merge(mdl_rd(int'(m_adr)), cpu_wdata, m_be);
          end
        end
        if (!creq || gc) m_streak = 0;
        else if (gv)     m_streak = (m_streak < VBURST) ? m_streak + 1 : VBURST;
      end
    end
  end

  task automatic cpu_op(input logic rd, input logic wr, input logic ben, input logic [23:0] adr,
                        input logic [31:0] wd, output int nst, output int nwe, output int tdone,
                        output logic [AW-1:0] a, output logic [3:0] be, output logic [31:0] rdat);
    nst = 0; nwe = 0; tdone = -1; a = '0; be = '0; rdat = '0;
    cpu_rd = rd; cpu_wr = wr; cpu_ben = ben; cpu_adr = adr; cpu_wdata = wd;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tdone < 0) begin
        if (stallX) nst++;
        else begin tdone = i; rdat = cpu_rdata; end
        if (sram_ce) begin a = sram_adr; be = sram_be; if (sram_we) nwe++; end
      end
      @(posedge clk); #1;
      if (tdone >= 0) begin cpu_rd = 0; cpu_wr = 0; end
    end
  endtask

  initial begin : stim
    int nst, nwe, td, tv, ta, ab, cnt;
    logic [AW-1:0] a;
    logic [3:0] be;
    logic [31:0] rdat;
    logic s, io_pick;
    int r;

    env_mem[32'h41] = 32'hDEADBEEF;
    mdl_mem[32'h41] = 32'hDEADBEEF;

    // reset with a CPU request present: no stall while in reset
    cpu_rd = 1; cpu_adr = 24'h000010;
    @(posedge clk); #1;
    model_on = 1'b1;
    @(negedge clk);
    chk("rst_stall", 32'(stallX), 32'h0);
    chk("rst_ce", 32'(sram_ce), 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_vid_ack", 32'(vid_ack), 32'h0);
    @(posedge clk); #1;
    rst = 1; cpu_rd = 0;
    repeat (2) @(posedge clk);
    #1;

    // uncontended load
    cpu_op(1, 0, 0, 24'h000104, 32'h0, nst, nwe, td, a, be, rdat);
    chk("rd_stall_cycles", 32'(nst), 32'd3);
    chk("rd_done_cycle", 32'(td), 32'd3);
    chk("rd_adr", 32'(a), 32'h41);
    chk("rd_be", 32'(be), 32'hF);
    chk("rd_data", rdat, 32'hDEADBEEF);

    // byte store to lane 3
    cpu_op(0, 1, 1, 24'h000203, 32'h5A5A5A5A, nst, nwe, td, a, be, rdat);
    chk("st_we_cycles", 32'(nwe), 32'd2);
    chk("st_be", 32'(be), 32'h8);
    chk("st_adr", 32'(a), 32'h80);
    chk("st_stall_cycles", 32'(nst), 32'd3);

    // contention: VBURST video words, then the CPU, then video again
    cpu_rd = 1; cpu_wr = 0; cpu_ben = 0; cpu_adr = 24'h000010; vid_req = 1; vid_adr = 18'h0002A;
    ab = 0; td = -1; ta = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (td < 0) begin
        if (vid_ack) ab++;
        if (!stallX) td = i;
      end else if (vid_ack && ta < 0) ta = i;
      @(posedge clk); #1;
      if (td >= 0) cpu_rd = 0;
      if (td >= 0 && vid_ack) vid_req = 0;
    end
    chk("burst_acks", 32'(ab), 32'(VBURST));
    chk("burst_cpu_done", 32'(td), 32'd15);
    chk("burst_resume", 32'(ta - td), 32'(WAIT + 2));

    // io region bypasses SRAM entirely
    cpu_rd = 1; cpu_adr = 24'hFFFFC4; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stallX || sram_ce) cnt++;
      @(posedge clk); #1;
    end
    cpu_rd = 0;
    chk("io_no_access", 32'(cnt), 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // video request one cycle after a CPU grant
    cpu_rd = 1; cpu_adr = 24'h000040; td = -1; tv = -1; ta = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!stallX && td < 0) td = i;
      if (sram_ce && !sram_we && sram_adr == 18'h123 && tv < 0) tv = i;
      if (vid_ack && ta < 0) ta = i;
      @(posedge clk); #1;
      if (i == 0) begin vid_req = 1; vid_adr = 18'h123; end
      if (td >= 0) cpu_rd = 0;
      if (vid_ack) vid_req = 0;
    end
    chk("late_vid_cpu_done", 32'(td), 32'd3);
    chk("late_vid_ack_after_done", 32'(ta - td), 32'(WAIT + 2));
    chk("late_vid_ack_latency", 32'(ta - tv), 32'(WAIT + 1));

    // reset in the second cycle of a video access
    vid_req = 1; vid_adr = 18'h00055;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_access_active", 32'(sram_ce), 32'h1);
    @(posedge clk); #1;
    rst = 0; vid_req = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("abort_ce_we_be", {28'h0, sram_ce, sram_we, sram_be[1:0]} | 32'(sram_be), 32'h0);
    chk("abort_adr", 32'(sram_adr), 32'h0);
    chk("abort_wdata", sram_wdata, 32'h0);
    chk("abort_cpu_rdata", cpu_rdata, 32'h0);
    chk("abort_vid_data", vid_data, 32'h0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (vid_ack) cnt++;
      @(negedge clk);
    end
    chk("abort_no_ack", 32'(cnt), 32'h0);
    @(posedge clk); #1;

    // randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      s = stallX;
      @(posedge clk); #1;
      rst = ($urandom_range(0, 79) != 0);
      if (!s) begin
        r = int'($urandom_range(0, 9));
        io_pick = (r == 9);
        cpu_rd = (r >= 4 && r <= 6) || (io_pick && $urandom_range(0, 1) == 0);
        cpu_wr = (r == 7 || r == 8) || (io_pick && !cpu_rd);
        cpu_ben = 1'($urandom_range(0, 1));
        cpu_wdata = $urandom;
        if (io_pick) cpu_adr = {18'h3FFFF, 6'($urandom_range(0, 63))};
        else cpu_adr = {4'($urandom_range(0, 15)), 18'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      end
      if (vid_ack || !vid_req) begin
        vid_req = ($urandom_range(0, 2) != 0);
        vid_adr = AW'($urandom_range(0, 15));
      end
    end
    rst = 1; cpu_rd = 0; cpu_wr = 0; vid_req = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
